// File: rtl/input_debouncer_pkg.sv
// debounce_pkg: shared types and helpers for the input debouncer.
//   debounce_state_t : stability FSM states
//   cnt_width()      : width of the qualification counter for a given STABLE_CYCLES
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } debounce_state_t;

  // Wide enough to hold 0..stable_cycles.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/input_debouncer_bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset; every stage loads RESET_VALUE
//   d   : asynchronous input
//   q   : synchronized output (last stage), valid STAGES edges after d settles
module bit_synchronizer #(
  parameter int unsigned STAGES      = 2,
  parameter bit          RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VALUE}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: turns a raw, bouncing asynchronous input into a clean level.
// The input is synchronized, then a stability FSM only accepts a level change
// once the synchronized input has held the new level for STABLE_CYCLES clocks.
//   clk       : single clock
//   rst       : synchronous active-high reset
//   a         : raw asynchronous input
//   debounced : registered clean level
//   busy      : high while a candidate change is being qualified
//   glitch    : registered one-cycle pulse when a pending change is abandoned
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic debounced,
  output logic busy,
  output logic glitch
);

  localparam int unsigned     CW          = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST    = CW'(STABLE_CYCLES - 1);
  localparam debounce_state_t RESET_STATE = RESET_VALUE ? STABLE_HI : STABLE_LO;

  logic            a_sync;
  debounce_state_t state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            debounced_n;
  logic            glitch_n;

  bit_synchronizer #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (a),
    .q   (a_sync)
  );

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_STATE;
      cnt       <= '0;
      debounced <= RESET_VALUE;
      glitch    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      debounced <= debounced_n;
      glitch    <= glitch_n;
    end
  end

  // Next-state logic. The first differing sample counts as cycle 1, so a
  // change is accepted on the sample where cnt already equals STABLE_CYCLES-1.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    debounced_n = debounced;
    glitch_n    = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (a_sync) begin
          if (STABLE_CYCLES == 1) begin
            state_n     = STABLE_HI;
            debounced_n = 1'b1;
          end else begin
            state_n = PEND_HI;
            cnt_n   = CW'(1);
          end
        end
      end
      PEND_HI: begin
        if (!a_sync) begin
          state_n  = STABLE_LO;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n     = STABLE_HI;
          cnt_n       = '0;
          debounced_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!a_sync) begin
          if (STABLE_CYCLES == 1) begin
            state_n     = STABLE_LO;
            debounced_n = 1'b0;
          end else begin
            state_n = PEND_LO;
            cnt_n   = CW'(1);
          end
        end
      end
      PEND_LO: begin
        if (a_sync) begin
          state_n  = STABLE_HI;
          cnt_n    = '0;
          glitch_n = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n     = STABLE_LO;
          cnt_n       = '0;
          debounced_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy = (state == PEND_HI) || (state == PEND_LO);
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer: two instances (STABLE_CYCLES=4 and =1) share
// one stimulus stream and are compared each cycle against a run-length model.
module tb_input_debouncer;

  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic deb0, busy0, gl0;
  logic deb1, busy1, gl1;

  always #5 clk = ~clk;

  input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(4), .RESET_VALUE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .a(a), .debounced(deb0), .busy(busy0), .glitch(gl0)
  );

  input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(1), .RESET_VALUE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .a(a), .debounced(deb1), .busy(busy1), .glitch(gl1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: delay line for the synchronizer, then a run length of
  // consecutive samples that differ from the accepted level.
  logic        sq[$];
  logic        m_deb[2];
  int unsigned m_run[2];
  logic        m_gl[2];
  int unsigned nst[2];
  int          rise_m[2], fall_m[2], rise_d[2], fall_d[2];
  logic        prev_d[2];

  task automatic model_step(input logic a_v, input logic rst_v);
    logic s;
    if (rst_v) begin
      sq.delete();
      repeat (SYNC) sq.push_back(1'b0);
      for (int i = 0; i < 2; i++) begin
        m_deb[i] = 1'b0;
        m_run[i] = 0;
        m_gl[i]  = 1'b0;
      end
    end else begin
      s = sq.pop_front();
      sq.push_back(a_v);
      for (int i = 0; i < 2; i++) begin
        if (s != m_deb[i]) begin
          m_gl[i] = 1'b0;
          m_run[i]++;
          if (m_run[i] == nst[i]) begin
            m_deb[i] = s;
            m_run[i] = 0;
            if (s) rise_m[i]++; else fall_m[i]++;
          end
        end else begin
          m_gl[i]  = (m_run[i] != 0);
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic cycle(input logic a_v, input logic rst_v);
    logic d[2];
    a   = a_v;
    rst = rst_v;
    @(posedge clk);
    model_step(a_v, rst_v);
    #1;
    check("deb0",    deb0,  m_deb[0]);
    check("busy0",   busy0, m_run[0] != 0);
    check("glitch0", gl0,   m_gl[0]);
    check("deb1",    deb1,  m_deb[1]);
    check("busy1",   busy1, m_run[1] != 0);
    check("glitch1", gl1,   m_gl[1]);
    d[0] = deb0;
    d[1] = deb1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_v) begin
        if (d[i] === 1'b1 && prev_d[i] === 1'b0) rise_d[i]++;
        if (d[i] === 1'b0 && prev_d[i] === 1'b1) fall_d[i]++;
      end
      prev_d[i] = d[i];
    end
  endtask

  // Hold a level and report when each instance's output reaches it.
  task automatic measure(input logic lvl, output int lat0, output int lat1, output int nbusy);
    lat0  = 0;
    lat1  = 0;
    nbusy = 0;
    for (int t = 1; t <= 12; t++) begin
      cycle(lvl, 1'b0);
      if (busy0 === 1'b1) nbusy++;
      if (deb0 === lvl && lat0 == 0) lat0 = t;
      if (deb1 === lvl && lat1 == 0) lat1 = t;
    end
  endtask

  int lat0, lat1, nbusy, ngl, r0, ever_hi;

  initial begin
    nst[0] = 4;
    nst[1] = 1;
    for (int i = 0; i < 2; i++) begin
      rise_m[i] = 0; fall_m[i] = 0; rise_d[i] = 0; fall_d[i] = 0;
      prev_d[i] = 1'b0;
    end
    repeat (SYNC) sq.push_back(1'b0);

    // Reset with a held high.
    cycle(1'b1, 1'b1);
    check("rst_deb",  deb0, 0);
    check("rst_busy", busy0, 0);
    check("rst_gl",   gl0, 0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check("post_rst_deb",  deb0, 0);
    check("post_rst_busy", busy0, 0);
    check("post_rst_gl",   gl0, 0);
    repeat (10) cycle(1'b0, 1'b0);

    // Clean rise.
    r0 = rise_d[0];
    measure(1'b1, lat0, lat1, nbusy);
    check("rise_lat",      lat0, 6);
    check("rise_lat_sc1",  lat1, 3);
    check("rise_busy",     nbusy, 3);
    check("rise_events",   rise_d[0] - r0, 1);

    // Clean fall.
    r0 = fall_d[0];
    measure(1'b0, lat0, lat1, nbusy);
    check("fall_lat",      lat0, 6);
    check("fall_lat_sc1",  lat1, 3);
    check("fall_busy",     nbusy, 3);
    check("fall_events",   fall_d[0] - r0, 1);

    // Short bounce: two cycles high.
    ngl = 0; ever_hi = 0;
    repeat (2) begin
      cycle(1'b1, 1'b0);
      if (gl0 === 1'b1) ngl++;
      if (deb0 !== 1'b0) ever_hi = 1;
    end
    repeat (10) begin
      cycle(1'b0, 1'b0);
      if (gl0 === 1'b1) ngl++;
      if (deb0 !== 1'b0) ever_hi = 1;
    end
    check("bounce_glitches", ngl, 1);
    check("bounce_deb",      ever_hi, 0);
    check("bounce_busy",     busy0, 0);

    // Abort in the last pending cycle, then a clean hold.
    ngl = 0; ever_hi = 0;
    repeat (3) begin
      cycle(1'b1, 1'b0);
      if (gl0 === 1'b1) ngl++;
      if (deb0 !== 1'b0) ever_hi = 1;
    end
    repeat (10) begin
      cycle(1'b0, 1'b0);
      if (gl0 === 1'b1) ngl++;
      if (deb0 !== 1'b0) ever_hi = 1;
    end
    check("late_abort_glitches", ngl, 1);
    check("late_abort_deb",      ever_hi, 0);
    measure(1'b1, lat0, lat1, nbusy);
    check("late_abort_relat", lat0, 6);
    repeat (10) cycle(1'b0, 1'b0);

    // Reset while qualifying a rise (cnt=2).
    repeat (4) cycle(1'b1, 1'b0);
    check("mid_pend_busy", busy0, 1);
    cycle(1'b1, 1'b1);
    check("mid_rst_deb",  deb0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_gl",   gl0, 0);
    cycle(1'b0, 1'b0);
    check("mid_rst_after_gl", gl0, 0);
    repeat (6) cycle(1'b0, 1'b0);

    // Randomized bursts with occasional resets.
    repeat (400) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      repeat (len) cycle(lvl, $urandom_range(0, 199) == 0);
    end

    check("rise_count0", rise_d[0], rise_m[0]);
    check("fall_count0", fall_d[0], fall_m[0]);
    check("rise_count1", rise_d[1], rise_m[1]);
    check("fall_count1", fall_d[1], fall_m[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
